// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset PC, NOP encoding, next-PC selects
// and the fetch control states.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_INSTR_W = 16;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] NOP          = 16'h0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_sel_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: instruction, next address and valid flag.
// Flush wins over hold; a flushed slot holds NOP with valid low.
module if_id_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_next_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_next_addr,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_next_addr;
  logic               r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_instr     <= INSTR_W'(NOP);
      r_next_addr <= '0;
      r_valid     <= 1'b0;
    end else if (i_flush) begin
      r_instr     <= INSTR_W'(NOP);
      r_next_addr <= '0;
      r_valid     <= 1'b0;
    end else if (!i_hold) begin
      r_instr     <= i_instr;
      r_next_addr <= i_next_addr;
      r_valid     <= 1'b1;
    end
  end

  assign o_instr     = r_instr;
  assign o_next_addr = r_next_addr;
  assign o_valid     = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, halt control and IF/ID buffer.
// Optional perf counters (cycle_count, stall_count) when FETCH_PERF_COUNTERS_EN is defined.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DEF_ADDR_W,
  parameter int unsigned        INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               hold,
  input  logic               flush,
  input  logic [1:0]         pc_sel,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [ADDR_W-1:0]  id_pc_next_address,
  output logic               id_valid,
  output logic               halted
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        stall_count
`endif
);

  logic [ADDR_W-1:0] r_pc;
  fetch_state_e      r_state;

  pc_sel_e           w_sel;
  logic              w_redirect;
  logic              w_running;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_plus2;
  logic              w_buf_flush;
  logic              w_buf_hold;

  assign w_sel      = pc_sel_e'(pc_sel);
  assign w_redirect = (w_sel == PC_BRANCH) || (w_sel == PC_JUMP);
  assign w_running  = (r_state == ST_RUN);
  assign w_target   = ((w_sel == PC_BRANCH) ? branch_target : jump_target) & ~ADDR_W'(1);
  assign w_pc_plus2 = r_pc + ADDR_W'(2);

  // A halt request beats a redirect on its edge: PC freezes and the slot is squashed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt)            r_state <= ST_HALTED;
          else if (w_redirect) r_pc    <= w_target;
          else if (!hold)      r_pc    <= w_pc_plus2;
        end
        default: r_state <= ST_HALTED;
      endcase
    end
  end

  assign w_buf_flush = w_running && (halt || w_redirect || flush);
  assign w_buf_hold  = !w_running || hold;

  if_id_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_hold      (w_buf_hold),
    .i_flush     (w_buf_flush),
    .i_instr     (imem_data),
    .i_next_addr (w_pc_plus2),
    .o_instr     (id_instruction),
    .o_next_addr (id_pc_next_address),
    .o_valid     (id_valid)
  );

  assign imem_addr = r_pc;
  assign halted    = (r_state == ST_HALTED);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else if (w_running) begin
      if (r_cycle_count != '1)         r_cycle_count <= r_cycle_count + 32'd1;
      if (hold && r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an IF/ID scoreboard queue.
module tb_fetch_stage;
  import cpu_pkg::*;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] nxt;
    logic        valid;
  } ifid_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        hold, flush, halt;
  logic [1:0]  pc_sel;
  logic [15:0] branch_target, jump_target;
  logic [15:0] id_instruction, id_pc_next_address;
  logic        id_valid, halted;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] cycle_count, stall_count;
`endif

  int unsigned total  = 0;
  int unsigned passes = 0;
  ifid_t       sb[$];

  fetch_stage #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .imem_addr          (imem_addr),
    .imem_data          (imem_data),
    .hold               (hold),
    .flush              (flush),
    .pc_sel             (pc_sel),
    .branch_target      (branch_target),
    .jump_target        (jump_target),
    .halt               (halt),
    .id_instruction     (id_instruction),
    .id_pc_next_address (id_pc_next_address),
    .id_valid           (id_valid),
    .halted             (halted)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .cycle_count        (cycle_count),
    .stall_count        (stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] imem_f(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0002: return 16'h5678;
      default:  return a ^ 16'hBEEF;
    endcase
  endfunction

  assign imem_data = imem_f(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] n, input logic v);
    ifid_t e;
    e.instr = i; e.nxt = n; e.valid = v;
    sb.push_back(e);
  endtask

  task automatic tick_check(input string tag);
    ifid_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, {16'h0, id_instruction}, {16'h0, e.instr});
      chk({tag, "_valid"}, {31'h0, id_valid}, {31'h0, e.valid});
      if (e.valid) chk({tag, "_next"}, {16'h0, id_pc_next_address}, {16'h0, e.nxt});
    end
  endtask

  task automatic chk_addr(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, imem_addr}, {16'h0, exp});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    {16'h0, imem_addr},          32'h0);
    chk({tag, "_instr"}, {16'h0, id_instruction},     {16'h0, NOP});
    chk({tag, "_next"},  {16'h0, id_pc_next_address}, 32'h0);
    chk({tag, "_valid"}, {31'h0, id_valid},           32'h0);
    chk({tag, "_halt"},  {31'h0, halted},             32'h0);
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0; halt = 1'b0;
    pc_sel = 2'b00; branch_target = '0; jump_target = '0;
    #2;
    chk_reset_vals("rst");
    @(negedge clock);
    reset = 1'b0;

    // Two sequential fetches
    push(16'h1234, 16'h0002, 1'b1); tick_check("f0"); chk_addr("f0_addr", 16'h0002);
    push(16'h5678, 16'h0004, 1'b1); tick_check("f1"); chk_addr("f1_addr", 16'h0004);

    // Hold for three cycles at PC=0004
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(16'h5678, 16'h0004, 1'b1); tick_check("hold"); chk_addr("hold_addr", 16'h0004);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    chk("stall_cnt", stall_count, 32'd3);
    chk("cycle_cnt", cycle_count, 32'd5);
`endif
    hold = 1'b0;

    push(imem_f(16'h0004), 16'h0006, 1'b1); tick_check("f2"); chk_addr("f2_addr", 16'h0006);

    // Branch with hold in same cycle; target bit 0 dropped
    pc_sel = 2'b01; branch_target = 16'h0041; hold = 1'b1;
    push(NOP, 16'h0000, 1'b0); tick_check("br"); chk_addr("br_addr", 16'h0040);
    pc_sel = 2'b00; hold = 1'b0;

    // Jump to odd address near the top, then wrap
    pc_sel = 2'b10; jump_target = 16'hFFFF;
    push(NOP, 16'h0000, 1'b0); tick_check("jmp"); chk_addr("jmp_addr", 16'hFFFE);
    pc_sel = 2'b00;
    push(imem_f(16'hFFFE), 16'h0000, 1'b1); tick_check("wrap"); chk_addr("wrap_addr", 16'h0000);

    // Reserved select behaves as sequential
    pc_sel = 2'b11;
    push(16'h1234, 16'h0002, 1'b1); tick_check("rsvd"); chk_addr("rsvd_addr", 16'h0002);
    pc_sel = 2'b00;

    // Flush alone advances PC; flush with hold freezes it
    flush = 1'b1;
    push(NOP, 16'h0000, 1'b0); tick_check("fl"); chk_addr("fl_addr", 16'h0004);
    hold = 1'b1;
    push(NOP, 16'h0000, 1'b0); tick_check("flh"); chk_addr("flh_addr", 16'h0004);
    flush = 1'b0; hold = 1'b0;

    // Get to 0010 and halt there
    pc_sel = 2'b10; jump_target = 16'h0010;
    push(NOP, 16'h0000, 1'b0); tick_check("j10"); chk_addr("j10_addr", 16'h0010);
    pc_sel = 2'b00; halt = 1'b1;
    push(NOP, 16'h0000, 1'b0); tick_check("halt"); chk_addr("halt_addr", 16'h0010);
    chk("halted", {31'h0, halted}, 32'h1);
    halt = 1'b0; pc_sel = 2'b10; jump_target = 16'h0100;
    push(NOP, 16'h0000, 1'b0); tick_check("hj"); chk_addr("hj_addr", 16'h0010);
    pc_sel = 2'b00;
    push(NOP, 16'h0000, 1'b0); tick_check("hs"); chk_addr("hs_addr", 16'h0010);
    chk("halted_sticky", {31'h0, halted}, 32'h1);

    // Reset exits halt
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_h");
    @(negedge clock);
    reset = 1'b0;
    push(16'h1234, 16'h0002, 1'b1); tick_check("rf0"); chk_addr("rf0_addr", 16'h0002);

    // Asynchronous reset between edges while a flush is pending
    flush = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_async");
`ifdef FETCH_PERF_COUNTERS_EN
    chk("cnt_rst", cycle_count, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b0; flush = 1'b0;
    push(16'h1234, 16'h0002, 1'b1); tick_check("af0"); chk_addr("af0_addr", 16'h0002);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
